// File: rtl/snake_game_sequencer.sv
// snake_game_sequencer: game FSM (idle/play/eat/over), head/apple positions and score, paced by frame_start
module snake_game_sequencer #(
  parameter int MOVE_FRAMES = 3,
  parameter int STEP        = 5,
  parameter int X_MIN       = 11,
  parameter int X_MAX       = 605,
  parameter int Y_MIN       = 11,
  parameter int Y_MAX       = 445,
  parameter int START_X     = 20,
  parameter int START_Y     = 20,
  parameter int APPLE_X0    = 300,
  parameter int APPLE_Y0    = 220,
  parameter int SCORE_W     = 8
) (
  input  logic               vga_clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic               start_btn,
  input  logic [1:0]         direction,
  input  logic               hit,
  input  logic [9:0]         rand_x,
  input  logic [9:0]         rand_y,
  output logic [9:0]         snake_x,
  output logic [9:0]         snake_y,
  output logic [9:0]         apple_x,
  output logic [9:0]         apple_y,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         state,
  output logic               move_tick
);
  localparam int FW = MOVE_FRAMES > 1 ? $clog2(MOVE_FRAMES) : 1;
  localparam logic [9:0] X0 = 10'(START_X);
  localparam logic [9:0] Y0 = 10'(START_Y);
  localparam logic [9:0] AX0 = 10'(APPLE_X0);
  localparam logic [9:0] AY0 = 10'(APPLE_Y0);
  localparam logic signed [10:0] S = 11'(STEP);
  localparam logic signed [10:0] XMN = 11'(X_MIN);
  localparam logic signed [10:0] XMX = 11'(X_MAX);
  localparam logic signed [10:0] YMN = 11'(Y_MIN);
  localparam logic signed [10:0] YMX = 11'(Y_MAX);
  typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, EAT = 2'b10, OVER = 2'b11} state_e;
  state_e state_q, state_d;
  logic [9:0] x_q, x_d, y_q, y_d, ax_q, ax_d, ay_q, ay_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [FW-1:0] cnt_q, cnt_d;
  logic hit_q, hit_d, btn_q, tick_q, tick_d;
  logic start_rise, move, out;
  logic signed [10:0] nx, ny;
  always_comb begin
    start_rise = start_btn & ~btn_q;
    move = frame_start & (cnt_q == FW'(MOVE_FRAMES - 1));
    // 11-bit signed so a left/up step below zero still compares as under the minimum
    nx = $signed({1'b0, x_q}) + (direction == 2'b01 ? S : direction == 2'b10 ? -S : 11'sd0);
    ny = $signed({1'b0, y_q}) + (direction == 2'b00 ? S : direction == 2'b11 ? -S : 11'sd0);
    out = (nx < XMN) | (nx > XMX) | (ny < YMN) | (ny > YMX);
    state_d = state_q;
    x_d = x_q;
    y_d = y_q;
    ax_d = ax_q;
    ay_d = ay_q;
    score_d = score_q;
    cnt_d = cnt_q;
    hit_d = 1'b0;
    tick_d = 1'b0;
    case (state_q)
      IDLE: begin
        x_d = X0;
        y_d = Y0;
        ax_d = AX0;
        ay_d = AY0;
        score_d = '0;
        if (start_rise) begin
          state_d = PLAY;
          cnt_d = '0;
        end
      end
      PLAY: begin
        hit_d = hit_q | hit;
        if (frame_start) cnt_d = move ? '0 : cnt_q + FW'(1);
        if (move && out) begin
          state_d = OVER;
          hit_d = 1'b0;
        end else begin
          if (move) begin
            x_d = nx[9:0];
            y_d = ny[9:0];
            tick_d = 1'b1;
          end
          // eat decision uses only hits latched before this frame_start
          if (frame_start && hit_q) begin
            state_d = EAT;
            hit_d = 1'b0;
          end
        end
      end
      EAT: begin
        ax_d = rand_x;
        ay_d = rand_y;
        score_d = &score_q ? score_q : score_q + SCORE_W'(1);
        state_d = PLAY;
      end
      OVER: begin
        if (start_rise) begin
          state_d = IDLE;
          x_d = X0;
          y_d = Y0;
          ax_d = AX0;
          ay_d = AY0;
          score_d = '0;
        end
      end
    endcase
  end
  always_ff @(posedge vga_clk) begin
    if (!reset) begin
      state_q <= IDLE;
      x_q <= X0;
      y_q <= Y0;
      ax_q <= AX0;
      ay_q <= AY0;
      score_q <= '0;
      cnt_q <= '0;
      hit_q <= 1'b0;
      btn_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      ax_q <= ax_d;
      ay_q <= ay_d;
      score_q <= score_d;
      cnt_q <= cnt_d;
      hit_q <= hit_d;
      btn_q <= start_btn;
      tick_q <= tick_d;
    end
  end
  assign snake_x = x_q;
  assign snake_y = y_q;
  assign apple_x = ax_q;
  assign apple_y = ay_q;
  assign score = score_q;
  assign state = state_q;
  assign move_tick = tick_q;
endmodule

// File: doc/snake_game_sequencer.md
# snake_game_sequencer

Game-level controller for the snake VGA design. Runs on the pixel clock and owns the game state machine (idle / play / eat / game-over), head position, apple position and score. Movement is paced by frame-start pulses from the VGA timing generator. It sequences apple respawn from the random coordinate generator and hands registered coordinates to the pixel-compare and RGB logic.

## Interface
Parameters:
- MOVE_FRAMES, 3: frame_start pulses per head step (≥1)
- STEP, 5: pixels moved per step
- X_MIN, 11 / X_MAX, 605: legal head-x range, inclusive
- Y_MIN, 11 / Y_MAX, 445: legal head-y range, inclusive
- START_X, 20 / START_Y, 20: head position after reset/restart
- APPLE_X0, 300 / APPLE_Y0, 220: apple position after reset/restart
- SCORE_W, 8: score width

Ports:
- vga_clk  in  1  pixel clock (25 MHz)
- reset  in  1  reset, synchronous, active-low
- frame_start  in  1  one-cycle pulse per frame (start of vertical blank)
- start_btn  in  1  start/restart button, synchronized level
- direction  in  2  10 left, 01 right, 11 up, 00 down
- hit  in  1  head/apple pixel overlap, per-pixel
- rand_x  in  10  candidate apple x
- rand_y  in  10  candidate apple y
- snake_x, snake_y  out  10  head top-left
- apple_x, apple_y  out  10  apple top-left
- score  out  SCORE_W  apples eaten
- state  out  2  00 IDLE, 01 PLAY, 10 EAT, 11 OVER
- move_tick  out  1  one-cycle pulse, head position just updated

## Operation
- Reset (reset=0 at vga_clk edge):
  - State goes to IDLE. Head is set to (START_X,START_Y) and apple to (APPLE_X0,APPLE_Y0).
  - score, move_tick, frame counter, hit flag and start_btn history register are all cleared.
  - Reset has priority over every other event.
- start_rise = start_btn & ~start_btn_q, registered every cycle.
- IDLE:
  - Head, apple and score are held at their start values.
  - start_rise moves to PLAY and clears the frame counter.
- PLAY:
  - hit=1 sets hit_flag. The flag is sticky until EAT or leaving PLAY.
  - Each frame_start increments frame_cnt, wrapping at MOVE_FRAMES-1. The frame_start on which frame_cnt==MOVE_FRAMES-1 is a move frame.
  - On a move frame, compute next = head ± STEP per direction in 11-bit signed arithmetic, so left/up underflow is detected as below the minimum.
  - If next is outside [X_MIN,X_MAX]×[Y_MIN,Y_MAX]: go to OVER. Head is not updated, no move_tick, and hit_flag is discarded.
  - Otherwise: head takes next and move_tick pulses.
  - On any frame_start with hit_flag=1 and no collision: go to EAT. Any move on that same frame is still applied.
- EAT (exactly one cycle):
  - apple_x/apple_y take rand_x/rand_y as sampled this cycle.
  - score increments, saturating at 2^SCORE_W-1.
  - hit_flag clears, then return to PLAY. hit during EAT is ignored.
- OVER:
  - Head, apple and score are frozen; hit is ignored.
  - start_rise moves to IDLE, which reloads start positions and clears score. A button held high through the transition into OVER does not restart the game.
- direction is sampled only on move frames; there is no reversal filtering.

## Timing
- All outputs are registered. The new head value and move_tick are visible one cycle after the frame_start edge.
- Eat latency: EAT state is visible 1 cycle after the frame_start edge; the new apple and score are visible 2 cycles after it.
- Each frame allows at most one move and at most one eat. Multiple hit pulses within a frame count as one apple.
- frame_start pulses in IDLE, EAT or OVER do not advance frame_cnt. A frame_start arriving in the EAT cycle is lost; this is acceptable because frame_start pulses are 420,000 cycles apart.
- Bounds are inclusive: with STEP 5, head x=15 stepping left gives 10, which is OVER.

## Test plan
- Reset: hold reset=0 for 2 cycles -> state 00, head (20,20), apple (300,220), score 0, move_tick 0.
- Movement: start_rise, direction=01, MOVE_FRAMES=3, 6 frame_start pulses -> exactly 2 move_tick pulses, final head (30,20), state 01.
- Collision: from (20,20), direction=10 -> first move gives x=15; next move frame -> state 11, head stays (15,20), no further move_tick on later frames.
- Eat: in PLAY, 3 hit pulses within one frame with rand_x=120, rand_y=340 held; then frame_start -> state 10 for 1 cycle, apple (120,340), score 1 (not 3), state 01.
- Saturation: SCORE_W=2, 5 eat events -> score 3 and stays 3.
- Restart/reset mid-play:
  - Enter OVER with start_btn held high -> stays 11; release then press -> 00 with start values.
  - Drive reset=0 during the EAT cycle -> next cycle state 00, score 0, apple (300,220).
